race_renderer: RTL and testbench

Pipelined, parametrised pixel renderer for the racing game. It takes the VGA pixel coordinate stream and outputs a 24-bit colour per pixel. It draws the road, the curbs, scrolling lane dashes, the player car and `N_OBS` obstacle cars, and it detects car/obstacle overlap once per frame. It sits between the VGA timing generator and the RGB output register, and its collision result feeds the game-control FSM.

---
 rtl/race_pkg.sv | 37 +++
 rtl/sprite_hit.sv | 45 ++++
 rtl/race_renderer.sv | 218 +++++++++++++++++++++
 tb/tb_race_renderer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared colours, road geometry and types for the race renderer.
package race_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COL_BG    = 24'h800000;
  localparam rgb_t COL_ROAD  = 24'h808080;
  localparam rgb_t COL_CURB  = 24'h8B4513;
  localparam rgb_t COL_WHITE = 24'hFFFFFF;
  localparam rgb_t COL_CAR   = 24'h000000;
  localparam rgb_t COL_OBS   = 24'hFF0000;

  localparam logic [9:0] ROAD_X0   = 10'd120;
  localparam logic [9:0] ROAD_X1   = 10'd520;
  localparam logic [9:0] CURB_L_X0 = 10'd110;
  localparam logic [9:0] CURB_L_X1 = 10'd120;
  localparam logic [9:0] CURB_R_X0 = 10'd520;
  localparam logic [9:0] CURB_R_X1 = 10'd530;
  localparam logic [9:0] LANE_A_X0 = 10'd248;
  localparam logic [9:0] LANE_A_X1 = 10'd258;
  localparam logic [9:0] LANE_B_X0 = 10'd382;
  localparam logic [9:0] LANE_B_X1 = 10'd392;

  typedef struct packed {
    logic road;
    logic curb;
    logic dash;
    logic car_body;
    logic car_detail;
  } bg_hits_t;

  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational body/detail hit test of one car sprite against the current pixel.
// Edges are widened by one bit so sprites near the right/bottom border never wrap.
module sprite_hit #(
  parameter int SPR_W = 50,
  parameter int SPR_H = 50
) (
  input  logic [9:0] px,
  input  logic [8:0] py,
  input  logic [9:0] h,
  input  logic [8:0] v,
  output logic       body,
  output logic       detail
);

  localparam logic [10:0] W_X = 11'(SPR_W);
  localparam logic [9:0]  H_Y = 10'(SPR_H);

  logic [10:0] xe, h0, h10, hw, hw10;
  logic [9:0]  ye, v0, v10, v20, vh;
  logic        in_x, in_y, head_x, head_y, scr_x, scr_y;

  assign xe   = {1'b0, px};
  assign h0   = {1'b0, h};
  assign h10  = h0 + 11'd10;
  assign hw   = h0 + W_X;
  assign hw10 = hw - 11'd10;

  assign ye  = {1'b0, py};
  assign v0  = {1'b0, v};
  assign v10 = v0 + 10'd10;
  assign v20 = v0 + 10'd20;
  assign vh  = v0 + H_Y;

  assign in_x   = (xe >= h0) && (xe < hw);
  assign in_y   = (ye >= v0) && (ye < vh);
  assign head_x = ((xe >= h0) && (xe < h10)) || ((xe >= hw10) && (xe < hw));
  assign head_y = (ye >= v0) && (ye < v10);
  // Windscreen strip spans between the headlights, one row band below them.
  assign scr_x  = (xe >= h10) && (xe < hw10);
  assign scr_y  = (ye >= v10) && (ye < v20);

  assign body   = in_x & in_y;
  assign detail = (head_x & head_y) | (scr_x & scr_y);

endmodule

// File: rtl/race_renderer.sv
// Two-stage pixel renderer: road, curbs, scrolling dashes, player car and obstacles.
// Define RACE_RENDERER_COLLISION_EN to build the per-frame collision accumulator.
module race_renderer
  import race_pkg::*;
#(
  parameter int N_OBS   = 2,
  parameter int SPR_W   = 50,
  parameter int SPR_H   = 50,
  parameter int DASH_P  = 24,
  parameter int DASH_ON = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic                 frame_start,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic [3:0]           scroll_speed,
  input  logic [9:0]           car_h,
  input  logic [8:0]           car_v,
  input  logic [10*N_OBS-1:0]  obs_h,
  input  logic [9*N_OBS-1:0]   obs_v,
  input  logic [N_OBS-1:0]     obs_en,
  output logic                 pixel_valid_out,
  output rgb_t                 pixel_data,
  output logic                 collision,
  output logic [N_OBS-1:0]     collision_mask
);

  localparam logic [7:0] P8        = 8'(DASH_P);
  localparam logic [7:0] ON8       = 8'(DASH_ON);
  localparam int         RED_STEPS = 15 / DASH_P + 1;

  logic             car_body, car_detail;
  logic [N_OBS-1:0] obs_body_raw, obs_detail_raw, obs_body, obs_detail;

  sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_car (
    .px(x), .py(y), .h(car_h), .v(car_v), .body(car_body), .detail(car_detail)
  );

  for (genvar g = 0; g < N_OBS; g++) begin : g_obs
    sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_obs (
      .px(x), .py(y), .h(obs_h[10*g +: 10]), .v(obs_v[9*g +: 9]),
      .body(obs_body_raw[g]), .detail(obs_detail_raw[g])
    );
  end

  assign obs_body   = obs_body_raw & obs_en;
  assign obs_detail = obs_detail_raw & obs_en;

  logic [7:0] off_q, off_d, off_sum;
  logic [7:0] y_mod, phase_raw, phase;
  logic       dash_lit;
  bg_hits_t   bg_now;

  always_comb begin
    y_mod     = 8'(y % 9'(DASH_P));
    phase_raw = y_mod + P8 - off_q;
    if (phase_raw >= P8) begin
      phase = phase_raw - P8;
    end else begin
      phase = phase_raw;
    end
    dash_lit = phase < ON8;

    bg_now.road       = in_span(x, ROAD_X0, ROAD_X1);
    bg_now.curb       = in_span(x, CURB_L_X0, CURB_L_X1) | in_span(x, CURB_R_X0, CURB_R_X1);
    bg_now.dash       = dash_lit & (in_span(x, LANE_A_X0, LANE_A_X1) |
                                    in_span(x, LANE_B_X0, LANE_B_X1));
    bg_now.car_body   = car_body;
    bg_now.car_detail = car_detail;
  end

  // The offset stays below DASH_P, so a few bounded subtractions reduce the sum.
  always_comb begin
    off_sum = off_q + {4'd0, scroll_speed};
    for (int i = 0; i < RED_STEPS; i++) begin
      if (off_sum >= P8) begin
        off_sum = off_sum - P8;
      end else begin
        off_sum = off_sum;
      end
    end
    if (frame_start) begin
      off_d = off_sum;
    end else begin
      off_d = off_q;
    end
  end

  logic             valid1_q, valid1_d;
  bg_hits_t         bg1_q, bg1_d;
  logic [N_OBS-1:0] ob1_q, ob1_d, od1_q, od1_d;

  always_comb begin
    valid1_d = pix_valid;
    if (pix_valid) begin
      bg1_d = bg_now;
      ob1_d = obs_body;
      od1_d = obs_detail;
    end else begin
      bg1_d = bg1_q;
      ob1_d = ob1_q;
      od1_d = od1_q;
    end
  end

  logic pixel_valid_q, pixel_valid_d;
  rgb_t pixel_data_q, pixel_data_d, colour;

  always_comb begin
    if (bg1_q.car_detail) begin
      colour = COL_WHITE;
    end else if (bg1_q.car_body) begin
      colour = COL_CAR;
    end else if (bg1_q.dash) begin
      colour = COL_WHITE;
    end else if (bg1_q.curb) begin
      colour = COL_CURB;
    end else if (bg1_q.road) begin
      colour = COL_ROAD;
    end else begin
      colour = COL_BG;
    end
    // Later obstacle channels paint over earlier ones.
    for (int i = 0; i < N_OBS; i++) begin
      if (od1_q[i]) begin
        colour = COL_WHITE;
      end else if (ob1_q[i]) begin
        colour = COL_OBS;
      end else begin
        colour = colour;
      end
    end
    pixel_valid_d = valid1_q;
    if (valid1_q) begin
      pixel_data_d = colour;
    end else begin
      pixel_data_d = pixel_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      off_q         <= 8'd0;
      valid1_q      <= 1'b0;
      bg1_q         <= bg_hits_t'(5'd0);
      ob1_q         <= {N_OBS{1'b0}};
      od1_q         <= {N_OBS{1'b0}};
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= 24'h000000;
    end else begin
      off_q         <= off_d;
      valid1_q      <= valid1_d;
      bg1_q         <= bg1_d;
      ob1_q         <= ob1_d;
      od1_q         <= od1_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
    end
  end

  assign pixel_valid_out = pixel_valid_q;
  assign pixel_data      = pixel_data_q;

`ifdef RACE_RENDERER_COLLISION_EN
  logic             fs1_q, fs1_d;
  logic [N_OBS-1:0] coll1_q, coll1_d, coll_new;
  logic [N_OBS-1:0] acc_q, acc_d, mask_q, mask_d;
  logic             collision_q, collision_d;

  // The delayed frame pulse lines up with the stage-1 flags of the same pixel.
  always_comb begin
    fs1_d = frame_start;
    if (pix_valid) begin
      coll1_d = obs_body & {N_OBS{car_body}};
    end else begin
      coll1_d = coll1_q;
    end
    if (valid1_q) begin
      coll_new = coll1_q;
    end else begin
      coll_new = {N_OBS{1'b0}};
    end
    if (fs1_q) begin
      mask_d = acc_q;
      acc_d  = coll_new;
    end else begin
      mask_d = mask_q;
      acc_d  = acc_q | coll_new;
    end
    collision_d = |mask_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fs1_q       <= 1'b0;
      coll1_q     <= {N_OBS{1'b0}};
      acc_q       <= {N_OBS{1'b0}};
      mask_q      <= {N_OBS{1'b0}};
      collision_q <= 1'b0;
    end else begin
      fs1_q       <= fs1_d;
      coll1_q     <= coll1_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      collision_q <= collision_d;
    end
  end

  assign collision_mask = mask_q;
  assign collision      = collision_q;
`else
  assign collision_mask = {N_OBS{1'b0}};
  assign collision      = 1'b0;
`endif

endmodule

// File: tb/tb_race_renderer.sv
// Randomised bench for race_renderer against a layered-painting reference model.
module tb_race_renderer;

  localparam int N_OBS   = 2;
  localparam int SPR_W   = 50;
  localparam int SPR_H   = 50;
  localparam int DASH_P  = 24;
  localparam int DASH_ON = 16;
`ifdef RACE_RENDERER_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                pix_valid = 1'b0;
  logic                frame_start = 1'b0;
  logic [9:0]          x = 10'd0;
  logic [8:0]          y = 9'd0;
  logic [3:0]          scroll_speed = 4'd0;
  logic [9:0]          car_h = 10'd0;
  logic [8:0]          car_v = 9'd0;
  logic [10*N_OBS-1:0] obs_h = '0;
  logic [9*N_OBS-1:0]  obs_v = '0;
  logic [N_OBS-1:0]    obs_en = '0;
  logic                pixel_valid_out;
  logic [23:0]         pixel_data;
  logic                collision;
  logic [N_OBS-1:0]    collision_mask;

  race_renderer #(.N_OBS(N_OBS), .SPR_W(SPR_W), .SPR_H(SPR_H),
                  .DASH_P(DASH_P), .DASH_ON(DASH_ON)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .frame_start(frame_start),
    .x(x), .y(y), .scroll_speed(scroll_speed), .car_h(car_h), .car_v(car_v),
    .obs_h(obs_h), .obs_v(obs_v), .obs_en(obs_en),
    .pixel_valid_out(pixel_valid_out), .pixel_data(pixel_data),
    .collision(collision), .collision_mask(collision_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v;
    logic [23:0]      col;
    logic [N_OBS-1:0] mask;
    int               want;
  } exp_t;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               off_m = 0;
  logic [N_OBS-1:0] acc_m = '0;
  logic [N_OBS-1:0] mask_m = '0;
  int               hs[N_OBS+1];
  int               vs[N_OBS+1];
  bit               ens[N_OBS+1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_box(int px, int py, int x0, int x1, int y0, int y1);
    return px >= x0 && px < x1 && py >= y0 && py < y1;
  endfunction

  function automatic bit spr_body(int k, int px, int py);
    return in_box(px, py, hs[k], hs[k] + SPR_W, vs[k], vs[k] + SPR_H);
  endfunction

  function automatic bit spr_det(int k, int px, int py);
    int h = hs[k];
    int v = vs[k];
    return in_box(px, py, h, h + 10, v, v + 10) ||
           in_box(px, py, h + SPR_W - 10, h + SPR_W, v, v + 10) ||
           in_box(px, py, h + 10, h + SPR_W - 10, v + 10, v + 20);
  endfunction

  // Paint layers bottom-up; whatever is painted last is what the screen shows.
  function automatic logic [23:0] ref_colour(int px, int py);
    logic [23:0] c = 24'h800000;
    bit lit = ((((py - off_m) % DASH_P) + DASH_P) % DASH_P) < DASH_ON;
    if (px >= 120 && px < 520) c = 24'h808080;
    if ((px >= 110 && px < 120) || (px >= 520 && px < 530)) c = 24'h8B4513;
    if (lit && ((px >= 248 && px < 258) || (px >= 382 && px < 392))) c = 24'hFFFFFF;
    if (spr_body(0, px, py)) c = 24'h000000;
    if (spr_det(0, px, py)) c = 24'hFFFFFF;
    for (int k = 1; k <= N_OBS; k++) begin
      if (ens[k] && spr_body(k, px, py)) c = 24'hFF0000;
      if (ens[k] && spr_det(k, px, py)) c = 24'hFFFFFF;
    end
    return c;
  endfunction

  task automatic place(input int k, input int h, input int v, input bit en);
    hs[k] = h; vs[k] = v; ens[k] = en;
    if (k == 0) begin
      car_h = h[9:0]; car_v = v[8:0];
    end else begin
      obs_h[10*(k-1) +: 10] = h[9:0];
      obs_v[9*(k-1) +: 9]   = v[8:0];
      obs_en[k-1]           = en;
    end
  endtask

  task automatic cycle(input bit v, input bit fs, input int px, input int py, input int want);
    exp_t e;
    exp_t o;
    logic [N_OBS-1:0] hits = '0;
    pix_valid = v; frame_start = fs; x = px[9:0]; y = py[8:0];
    for (int k = 1; k <= N_OBS; k++)
      hits[k-1] = v && ens[k] && spr_body(0, px, py) && spr_body(k, px, py);
    e.v = v; e.col = ref_colour(px, py); e.want = want;
    if (fs) begin
      mask_m = acc_m;
      acc_m  = hits;
      off_m  = (off_m + int'(scroll_speed)) % DASH_P;
    end else begin
      acc_m = acc_m | hits;
    end
    e.mask = mask_m;
    exp_q.push_back(e);
    @(posedge clk); #1;
    o = exp_q.pop_front();
    chk("valid", 32'(pixel_valid_out), 32'(o.v));
    if (o.v) chk("pixel", 32'(pixel_data), 32'(o.col));
    if (o.want >= 0) chk("plan_pixel", 32'(pixel_data), 32'(o.want));
    chk("mask", 32'(collision_mask), COLL_EN ? 32'(o.mask) : 32'd0);
    chk("coll", 32'(collision), COLL_EN ? 32'(|o.mask) : 32'd0);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pixel_valid_out), 32'd0);
    chk("rst_data", 32'(pixel_data), 32'd0);
    chk("rst_mask", 32'(collision_mask), 32'd0);
    chk("rst_coll", 32'(collision), 32'd0);
    rst_n = 1'b1;
    off_m = 0; acc_m = '0; mask_m = '0;
    exp_q.delete();
    e.v = 1'b0; e.col = 24'h0; e.mask = '0; e.want = -1;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int k = 0; k <= N_OBS; k++) place(k, 0, 0, 1'b0);
    place(0, 1000, 500, 1'b1);
    do_reset(3);

    // Background layers with no sprite in view.
    cycle(1, 0, 250, 5, 24'hFFFFFF);
    cycle(1, 0, 300, 5, 24'h808080);
    cycle(1, 0, 115, 5, 24'h8B4513);
    cycle(1, 0, 50, 5, 24'h800000);

    // Obstacle stacked on the car.
    place(0, 200, 400, 1'b1);
    place(1, 200, 400, 1'b1);
    cycle(1, 0, 205, 405, 24'hFFFFFF);
    cycle(1, 0, 230, 440, 24'hFF0000);
    cycle(0, 0, 0, 0, -1);
    cycle(0, 1, 0, 0, -1);
    cycle(0, 0, 0, 0, -1);
    chk("plan_mask_set", 32'(collision_mask), COLL_EN ? 32'd1 : 32'd0);
    chk("plan_coll_set", 32'(collision), COLL_EN ? 32'd1 : 32'd0);

    place(1, 600, 100, 1'b1);
    cycle(1, 0, 205, 405, -1);
    cycle(0, 1, 0, 0, -1);
    cycle(0, 0, 0, 0, -1);
    chk("plan_mask_clr", 32'(collision_mask), 32'd0);

    // Five frames at speed 5 leave the offset at 1.
    scroll_speed = 4'd5;
    repeat (5) cycle(0, 1, 0, 0, -1);
    scroll_speed = 4'd0;
    place(0, 1000, 500, 1'b1);
    place(1, 0, 0, 1'b0);
    cycle(1, 0, 250, 0, 24'h808080);
    cycle(1, 0, 250, 1, 24'hFFFFFF);

    // Sprites near the right and bottom borders must not wrap.
    place(2, 1000, 0, 1'b1);
    cycle(1, 0, 4, 5, 24'h800000);
    cycle(1, 0, 1010, 20, 24'hFF0000);
    cycle(1, 0, 1005, 5, 24'hFFFFFF);
    place(2, 20, 500, 1'b1);
    cycle(1, 0, 25, 2, 24'h800000);
    place(2, 0, 0, 1'b0);

    // Reset after an overlap drops the accumulated hit.
    place(0, 200, 400, 1'b1);
    place(1, 200, 400, 1'b1);
    cycle(1, 0, 210, 420, -1);
    do_reset(2);
    cycle(0, 1, 0, 0, -1);
    cycle(0, 0, 0, 0, -1);
    chk("plan_mask_rst", 32'(collision_mask), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      int px = $urandom_range(0, 1023);
      int py = $urandom_range(0, 511);
      if ($urandom_range(0, 15) == 0) scroll_speed = 4'($urandom_range(0, 15));
      for (int k = 0; k <= N_OBS; k++) begin
        if ($urandom_range(0, 7) == 0)
          place(k, (px + 1024 - $urandom_range(0, 59)) % 1024,
                   (py + 512 - $urandom_range(0, 59)) % 512,
                   (k == 0) || ($urandom_range(0, 3) != 0));
      end
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 59) == 0, px, py, -1);
    end
    repeat (3) cycle(0, 0, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
